bru_redirect_unit: RTL and testbench

Branch resolution stage directly downstream of the branch execution decoder. Registers each resolved branch outcome (taken, target, PC), compares it against the frontend's prediction carried with the instruction, reports completion to the ROB and, on a mispredict, raises a backend flush and holds a fetch redirect until the frontend accepts it. After a redirect it back-pressures the branch unit for a programmable drain window and keeps branch and mispredict performance counters.

---
 rtl/bru_pkg.sv | 14 +
 rtl/bru_perf_counter.sv | 16 +
 rtl/bru_redirect_unit.sv | 83 ++++++++
 tb/tb_bru_redirect_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// bru_pkg: shared types and constants for the branch redirect unit.
package bru_pkg;
  localparam int INSN_BYTES = 4;
  localparam int TAG_W = 6;
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} bru_state_e;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             mispred;
  } branch_resolve_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
  } redirect_t;
endpackage

// File: rtl/bru_perf_counter.sv
// bru_perf_counter: enable-driven wrapping event counter.
module bru_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  end
  assign count_o = cnt_q;
endmodule

// File: rtl/bru_redirect_unit.sv
// bru_redirect_unit: resolves branches against prediction, reports to ROB, flushes and redirects fetch.
module bru_redirect_unit
  import bru_pkg::*;
#(
  parameter int ROB_TAG_W    = 6,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_taken,
  input  logic [63:0]          in_target,
  input  logic [63:0]          in_pc,
  input  logic [ROB_TAG_W-1:0] in_rob_tag,
  input  logic                 in_pred_taken,
  input  logic [63:0]          in_pred_target,
  output logic                 rob_resolve_valid,
  output logic [ROB_TAG_W-1:0] rob_resolve_tag,
  output logic                 rob_resolve_mispred,
  output logic                 flush_valid,
  output logic [ROB_TAG_W-1:0] flush_tag,
  output logic                 fe_redirect_valid,
  output logic [63:0]          fe_redirect_pc,
  input  logic                 fe_redirect_ready,
  output logic [CNT_W-1:0]     branch_count,
  output logic [CNT_W-1:0]     mispred_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  bru_state_e      state_q;
  logic [DW-1:0]   drain_q;
  branch_resolve_t res_q;
  redirect_t       redir_q;
  logic            rv_q, flush_q;
  logic            accept, mispred;
  logic [63:0]     seq_pc, act_pc, pred_pc;
  // Ready depends only on state and reset, never on in_valid.
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign seq_pc   = in_pc + 64'(INSN_BYTES);
  assign act_pc   = in_taken ? in_target : seq_pc;
  assign pred_pc  = in_pred_taken ? in_pred_target : seq_pc;
  assign mispred  = act_pc != pred_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      res_q   <= '0;
      redir_q <= '0;
      rv_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      rv_q    <= accept;
      flush_q <= accept && mispred;
      if (accept) res_q <= '{tag: TAG_W'(in_rob_tag), mispred: mispred};
      if (state_q == IDLE && accept && mispred) begin
        state_q <= REDIRECT;
        redir_q <= '{valid: 1'b1, pc: act_pc};
      end else if (state_q == REDIRECT && fe_redirect_ready) begin
        state_q       <= DRAIN;
        drain_q       <= DW'(DRAIN_CYCLES);
        redir_q.valid <= 1'b0;
      end else if (state_q == DRAIN) begin
        drain_q <= drain_q - DW'(1);
        if (drain_q == DW'(1)) state_q <= IDLE;
      end
    end
  end
  assign rob_resolve_valid   = rv_q;
  assign rob_resolve_tag     = ROB_TAG_W'(res_q.tag);
  assign rob_resolve_mispred = res_q.mispred;
  assign flush_valid         = flush_q;
  assign flush_tag           = ROB_TAG_W'(res_q.tag);
  assign fe_redirect_valid   = redir_q.valid;
  assign fe_redirect_pc      = redir_q.pc;
  bru_perf_counter #(.W(CNT_W)) u_branch_cnt (
    .clk(clk), .rst(rst), .en_i(accept), .count_o(branch_count)
  );
  bru_perf_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk(clk), .rst(rst), .en_i(accept && mispred), .count_o(mispred_count)
  );
endmodule

// File: tb/tb_bru_redirect_unit.sv
// tb_bru_redirect_unit: directed plan plus random traffic against a transaction-level reference model.
module tb_bru_redirect_unit;
  localparam int DRAIN = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 0, in_ready, in_taken = 0, in_pred_taken = 0;
  logic [63:0] in_target = 0, in_pc = 0, in_pred_target = 0;
  logic [5:0] in_rob_tag = 0;
  logic rob_resolve_valid, rob_resolve_mispred, flush_valid, fe_redirect_valid;
  logic [5:0] rob_resolve_tag, flush_tag;
  logic [63:0] fe_redirect_pc;
  logic fe_redirect_ready = 0;
  logic [31:0] branch_count, mispred_count;
  int errors = 0, checks = 0;
  int cyc = 0;
  // reference model: pending redirect, cycle at which input reopens, last resolve
  logic m_pend = 0, m_rv = 0, m_rmis = 0;
  logic [63:0] m_rpc = 0;
  logic [5:0] m_rtag = 0;
  logic [31:0] m_bc = 0, m_mc = 0;
  int m_ready_at = 0;
  bru_redirect_unit #(.ROB_TAG_W(6), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_taken(in_taken),
    .in_target(in_target), .in_pc(in_pc), .in_rob_tag(in_rob_tag),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .rob_resolve_valid(rob_resolve_valid), .rob_resolve_tag(rob_resolve_tag),
    .rob_resolve_mispred(rob_resolve_mispred), .flush_valid(flush_valid), .flush_tag(flush_tag),
    .fe_redirect_valid(fe_redirect_valid), .fe_redirect_pc(fe_redirect_pc),
    .fe_redirect_ready(fe_redirect_ready), .branch_count(branch_count), .mispred_count(mispred_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic check_outputs();
    check("in_ready", 64'(in_ready), 64'(!rst && !m_pend && cyc >= m_ready_at));
    check("rob_v", 64'(rob_resolve_valid), 64'(m_rv));
    if (m_rv) begin
      check("rob_tag", 64'(rob_resolve_tag), 64'(m_rtag));
      check("rob_mis", 64'(rob_resolve_mispred), 64'(m_rmis));
    end
    check("flush_v", 64'(flush_valid), 64'(m_rv && m_rmis));
    if (m_rv && m_rmis) check("flush_tag", 64'(flush_tag), 64'(m_rtag));
    check("redir_v", 64'(fe_redirect_valid), 64'(m_pend));
    if (m_pend) check("redir_pc", fe_redirect_pc, m_rpc);
    check("br_cnt", 64'(branch_count), 64'(m_bc));
    check("mis_cnt", 64'(mispred_count), 64'(m_mc));
  endtask
  // Advance one clock: update the model from the inputs present at this edge, then check.
  task automatic tick();
    logic acc, mis;
    logic [63:0] act, pred;
    if (rst) begin
      m_pend = 0; m_rv = 0; m_rmis = 0; m_rpc = 0; m_rtag = 0;
      m_bc = 0; m_mc = 0; m_ready_at = 0;
    end else begin
      act  = in_taken ? in_target : in_pc + 64'd4;
      pred = in_pred_taken ? in_pred_target : in_pc + 64'd4;
      mis  = act != pred;
      acc  = in_valid && !m_pend && cyc >= m_ready_at;
      m_rv = acc;
      if (acc) begin m_rtag = in_rob_tag; m_rmis = mis; m_bc++; end
      if (acc && mis) m_mc++;
      if (m_pend && fe_redirect_ready) begin m_pend = 0; m_ready_at = cyc + 1 + DRAIN; end
      if (acc && mis) begin m_pend = 1; m_rpc = act; end
    end
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask
  task automatic set_br(input logic v, input logic tk, input logic [63:0] tgt, input logic [63:0] pc,
                        input logic [5:0] tag, input logic pt, input logic [63:0] ptgt);
    in_valid = v; in_taken = tk; in_target = tgt; in_pc = pc;
    in_rob_tag = tag; in_pred_taken = pt; in_pred_target = ptgt;
  endtask
  initial begin
    @(negedge clk);
    repeat (3) tick();
    rst = 0;
    tick();
    check("rst_cnt", 64'(branch_count), 64'd0);
    // correct taken branch
    set_br(1, 1, 64'h2000, 64'h1000, 6'd5, 1, 64'h2000);
    tick();
    in_valid = 0;
    check("t1_tag", 64'(rob_resolve_tag), 64'd5);
    check("t1_bc", 64'(branch_count), 64'd1);
    tick();
    // not-taken mispredict, fetch stalls three cycles
    set_br(1, 0, 64'h0, 64'h1000, 6'd7, 1, 64'h2000);
    tick();
    in_valid = 0;
    check("t2_pc", fe_redirect_pc, 64'h1004);
    check("t2_ftag", 64'(flush_tag), 64'd7);
    repeat (3) tick();
    fe_redirect_ready = 1;
    tick();
    fe_redirect_ready = 0;
    repeat (DRAIN + 1) tick();
    check("t2_mc", 64'(mispred_count), 64'd1);
    // target-only mispredict, ready already high in first redirect cycle
    set_br(1, 1, 64'h3000, 64'h1000, 6'd9, 1, 64'h2000);
    fe_redirect_ready = 1;
    tick();
    in_valid = 0;
    check("t3_pc", fe_redirect_pc, 64'h3000);
    check("t3_mis", 64'(rob_resolve_mispred), 64'd1);
    tick();
    fe_redirect_ready = 0;
    repeat (DRAIN + 1) tick();
    // back-to-back correct stream
    for (int i = 1; i <= 4; i++) begin
      set_br(1, 0, 64'h0, 64'h4000 + 64'(i * 8), 6'(i), 0, 64'h0);
      tick();
    end
    in_valid = 0;
    tick();
    // wrap-around next PC, then reset while redirect pending
    set_br(1, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 6'd3, 1, 64'h2000);
    tick();
    in_valid = 0;
    check("wrap_pc", fe_redirect_pc, 64'h0);
    tick();
    rst = 1;
    tick();
    check("rst_rv", 64'(fe_redirect_valid), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd0);
    tick();
    rst = 0;
    #1 check("rst_rdy1", 64'(in_ready), 64'd1);
    tick();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      set_br($urandom_range(0, 3) != 0, 1'($urandom),
             64'h2000 + 64'($urandom_range(0, 2) * 64'h1000),
             ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom} & ~64'h3,
             6'($urandom), 1'($urandom),
             64'h2000 + 64'($urandom_range(0, 2) * 64'h1000));
      if ($urandom_range(0, 3) == 0) in_taken = in_pred_taken;
      if ($urandom_range(0, 3) == 0) in_target = in_pred_target;
      fe_redirect_ready = $urandom_range(0, 2) == 0;
      rst = $urandom_range(0, 60) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
